// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width; a 1-bit floor keeps the vector legal for tiny widths.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell shared by the serial adder datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB-first, start/done handshake.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Handshake: start is accepted on an edge where busy=0 (IDLE or DONE);
  // done is a one-cycle pulse and sum/cout are valid from then until the next acceptance.
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    res_d = {fa_s, res_q[WIDTH-1:1]};
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= fa_co;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          if (cnt_q == LAST_BIT) begin
            // Counter holds at the last bit rather than wrapping.
            sum_q   <= res_d;
            cout_q  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= carry_q ^ fa_co;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8); checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk, rst_n, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         ovf_bit;

  int total = 0;
  int bad   = 0;
  logic [W+1:0] exp_q[$];

`ifdef SERIAL_ADD_OVF_EN
  logic ovf;
  assign ovf_bit = ovf;
`else
  assign ovf_bit = 1'b0;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] res_word(input logic [W-1:0] s, input logic c, input logic o);
`ifdef SERIAL_ADD_OVF_EN
    return {o, c, s};
`else
    return {1'b0, c, s};
`endif
  endfunction

  // driver tasks
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    if (done !== 1'b1) check_val({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_noexp"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_res"}, 32'(res_word(sum, cout, ovf_bit)), 32'(e));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat, bc;
    exp_q.push_back(res_word(es, ec, eo));
    issue(av, bv, cv);
    wait_done(tag, lat, bc);
    check_val({tag, "_lat"}, 32'(lat), 32'd9);
    check_val({tag, "_busy"}, 32'(bc), 32'd8);
    check_result(tag);
    @(negedge clk);
    check_val({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bc, dn;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_res", 32'(res_word(sum, cout, ovf_bit)), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("t2b", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // start held high with changing operands during RUN
    exp_q.push_back(res_word(8'h02, 1'b0, 1'b0));
    exp_q.push_back(res_word(8'h33, 1'b0, 1'b0));
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'h11; b = 8'h22;
    wait_done("t3a", lat, bc);
    check_val("t3a_lat", 32'(lat), 32'd9);
    check_val("t3a_busy", 32'(bc), 32'd8);
    check_result("t3a");
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t3b", lat, bc);
    check_val("t3b_lat", 32'(lat), 32'd9);
    check_result("t3b");
    @(negedge clk);

    // start pulse in the DONE cycle
    exp_q.push_back(res_word(8'h08, 1'b0, 1'b0));
    exp_q.push_back(res_word(8'h30, 1'b0, 1'b0));
    issue(8'h05, 8'h03, 1'b0);
    wait_done("t4a", lat, bc);
    check_result("t4a");
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t4b", lat, bc);
    check_val("t4b_lat", 32'(lat), 32'd9);
    check_val("t4b_busy", 32'(bc), 32'd8);
    check_result("t4b");
    @(negedge clk);

    // reset mid-RUN
    issue(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    check_val("t5_busy_pre", 32'(busy), 32'd1);
    check_val("t5_sum_held", 32'(sum), 32'h30);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_res", 32'(res_word(sum, cout, ovf_bit)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_val("t5_no_done", 32'(dn), 32'd0);
    run_op("t5b", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);

    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
